// File: rtl/wide_alu_chunked.sv
// Wide ALU core: ADD/SUB/AND/OR/XOR on two OP_WIDTH-bit operands, evaluated one
// CHUNK_WIDTH slice per step with a rippled carry. A programmable deaccel factor
// inserts wait cycles ahead of every slice. Status exposes state, a sticky error
// flag, and carry/zero flags of the last completed operation.
module wide_alu_chunked #(
  parameter int OP_WIDTH    = 1024,
  parameter int CHUNK_WIDTH = 64,
  parameter int DELAY_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   trigger_i,
  input  logic                   clear_err_i,
  input  logic [OP_WIDTH-1:0]    op_a_i,
  input  logic [OP_WIDTH-1:0]    op_b_i,
  input  logic                   op_sel_we_i,
  input  logic [2:0]             op_sel_i,
  output logic [2:0]             op_sel_o,
  input  logic                   deaccel_factor_we_i,
  input  logic [DELAY_WIDTH-1:0] deaccel_factor_i,
  output logic [DELAY_WIDTH-1:0] deaccel_factor_o,
  output logic [OP_WIDTH-1:0]    result_o,
  output logic [4:0]             status_o
);

  localparam int NCH   = OP_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Architectural registers
  state_t                 state_reg;
  logic [2:0]             op_sel_reg;
  logic [DELAY_WIDTH-1:0] deaccel_reg;
  logic [OP_WIDTH-1:0]    result_reg;
  logic                   err_reg;
  logic                   carry_reg;
  logic                   zero_reg;

  // Operation context latched at the start edge
  logic [OP_WIDTH-1:0]    a_reg;
  logic [OP_WIDTH-1:0]    b_reg;
  logic [2:0]             op_reg;
  logic [DELAY_WIDTH-1:0] d_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [DELAY_WIDTH-1:0] wait_reg;
  logic                   carry_run_reg;

  // Slice datapath
  logic [CHUNK_WIDTH-1:0] a_slices [NCH];
  logic [CHUNK_WIDTH-1:0] b_slices [NCH];
  logic [CHUNK_WIDTH-1:0] a_cur;
  logic [CHUNK_WIDTH-1:0] b_cur;
  logic [CHUNK_WIDTH-1:0] b_eff;
  logic [CHUNK_WIDTH:0]   sum_ext;
  logic [CHUNK_WIDTH-1:0] slice_val;
  logic                   slice_cout;
  logic [OP_WIDTH-1:0]    result_next;

  // Error bookkeeping
  logic is_busy;
  logic err_set;
  logic err_next;

  // Split operands into slices and build the result with the current slice merged in
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
      assign a_slices[gi] = a_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
      assign b_slices[gi] = b_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
      assign result_next[gi*CHUNK_WIDTH +: CHUNK_WIDTH] =
        (idx_reg == IDX_W'(gi)) ? slice_val : result_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
    end
  endgenerate

  assign a_cur = a_slices[idx_reg];
  assign b_cur = b_slices[idx_reg];

  // Evaluate the active slice; SUB is A + ~B with the carry seeded to 1 at start
  always_comb begin
    b_eff      = (op_reg == OP_SUB) ? ~b_cur : b_cur;
    sum_ext    = {1'b0, a_cur} + {1'b0, b_eff} + {{CHUNK_WIDTH{1'b0}}, carry_run_reg};
    slice_val  = '0;
    slice_cout = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: begin
        slice_val  = sum_ext[CHUNK_WIDTH-1:0];
        slice_cout = sum_ext[CHUNK_WIDTH];
      end
      OP_AND: slice_val = a_cur & b_cur;
      OP_OR:  slice_val = a_cur | b_cur;
      OP_XOR: slice_val = a_cur ^ b_cur;
      default: begin
        slice_val  = '0;
        slice_cout = 1'b0;
      end
    endcase
  end

  // Sticky error: any set event wins over a simultaneous clear
  always_comb begin
    is_busy  = (state_reg == ST_BUSY);
    err_set  = is_busy ? (trigger_i | op_sel_we_i | deaccel_factor_we_i)
                       : (op_sel_we_i & (op_sel_i > OP_XOR));
    err_next = err_set | (err_reg & ~clear_err_i);
  end

  // Control FSM with config registers, slice sequencing and flag updates
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      op_sel_reg    <= OP_ADD;
      deaccel_reg   <= '0;
      result_reg    <= '0;
      err_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= OP_ADD;
      d_reg         <= '0;
      idx_reg       <= '0;
      wait_reg      <= '0;
      carry_run_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // New config lands on the same edge as a start, but the start uses the old values
          if (op_sel_we_i && (op_sel_i <= OP_XOR)) begin
            op_sel_reg <= op_sel_i;
          end
          if (deaccel_factor_we_i) begin
            deaccel_reg <= deaccel_factor_i;
          end
          if (trigger_i) begin
            a_reg         <= op_a_i;
            b_reg         <= op_b_i;
            op_reg        <= op_sel_reg;
            d_reg         <= deaccel_reg;
            result_reg    <= '0;
            idx_reg       <= '0;
            wait_reg      <= deaccel_reg;
            zero_reg      <= 1'b1;
            carry_run_reg <= (op_sel_reg == OP_SUB);
            state_reg     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (wait_reg != '0) begin
            wait_reg <= wait_reg - DELAY_WIDTH'(1);
          end else begin
            result_reg    <= result_next;
            carry_run_reg <= slice_cout;
            zero_reg      <= zero_reg & (slice_val == '0);
            wait_reg      <= d_reg;
            idx_reg       <= idx_reg + IDX_W'(1);
            if (idx_reg == LAST_IDX) begin
              // Logical ops produce slice_cout=0, so carry is forced low for them
              carry_reg <= slice_cout;
              state_reg <= ST_DONE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign op_sel_o         = op_sel_reg;
  assign deaccel_factor_o = deaccel_reg;
  assign result_o         = result_reg;
  assign status_o         = {zero_reg, carry_reg, err_reg, state_reg};

endmodule
